// File: rtl/reaction_timer_core_pkg.sv
// -----------------------------------------------------------------------------
// reaction_timer_core_pkg
// Shared constants for the reaction timer: display sentinels, the saturation
// limit of the reaction count, the FSM state encoding and the LFSR step
// function used by lfsr16.
// -----------------------------------------------------------------------------
package reaction_timer_core_pkg;

  // Display codes outside 0..9999 so the decoder can tell them from a count
  localparam logic [13:0] SENT_FAIL      = 14'h3FFF;
  localparam logic [13:0] SENT_IDLE      = 14'h3FFE;
  localparam logic [13:0] SENT_LED_BLANK = 14'h3FFD;
  localparam logic [13:0] MAX_MS         = 14'd9999;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WAIT   = 3'd1,
    ST_ARMED  = 3'd2,
    ST_RESULT = 3'd3,
    ST_FAIL   = 3'd4
  } state_e;

  // One step of the x^16 + x^14 + x^13 + x^11 + 1 Fibonacci LFSR
  function automatic logic [15:0] lfsr16_next(input logic [15:0] cur);
    logic fb;
    fb = cur[15] ^ cur[13] ^ cur[12] ^ cur[10];
    return {cur[14:0], fb};
  endfunction

endpackage

// File: rtl/reaction_timer_core_lfsr16.sv
// -----------------------------------------------------------------------------
// lfsr16
// Free-running 16-bit maximal-length LFSR, stepped every clock cycle.
// Ports:
//   clock_i  system clock
//   reset_i  synchronous active-high reset, loads SEED
//   lfsr_o   current LFSR state
// -----------------------------------------------------------------------------
module lfsr16
  import reaction_timer_core_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clock_i,
  input  logic        reset_i,
  output logic [15:0] lfsr_o
);

  // A zero seed would lock the register up, so it is replaced by 1
  localparam logic [15:0] SAFE_SEED = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [15:0] lfsr_q;
  logic [15:0] lfsr_d;

  // Next LFSR state; an all-zero state (only reachable by an upset) recovers
  always_comb begin
    lfsr_d = SAFE_SEED;
    if (lfsr_q == 16'h0000) begin
      lfsr_d = SAFE_SEED;
    end else begin
      lfsr_d = lfsr16_next(lfsr_q);
    end
  end

  // LFSR state register
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      lfsr_q <= SAFE_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lfsr_o = lfsr_q;

endmodule

// File: rtl/reaction_timer_core.sv
// -----------------------------------------------------------------------------
// reaction_timer_core
// Reaction-time game: a start press arms a random delay, after which the
// stimulus LED lights and the user's reaction time is counted in ms.
// Ports:
//   clock             system clock (single domain)
//   reset             synchronous active-high reset
//   rising_edge_1khz  one-cycle strobe, once per millisecond
//   start_button      debounced level, rising edge starts/restarts a trial
//   react_button      debounced level, rising edge is the reaction
//   time_millisecs    registered display code (0..9999 or sentinel)
//   display_enable    registered, 1 = display anodes active
//   stimulus_led      registered, 1 = stimulus lit
// -----------------------------------------------------------------------------
module reaction_timer_core
  import reaction_timer_core_pkg::*;
#(
  parameter int          MIN_DELAY_MS = 1000,
  parameter int          RAND_BITS    = 11,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rising_edge_1khz,
  input  logic        start_button,
  input  logic        react_button,
  output logic [13:0] time_millisecs,
  output logic        display_enable,
  output logic        stimulus_led
);

  // The delay counter is 16 bits: MIN_DELAY_MS + 2^RAND_BITS - 1 must fit
  localparam logic [15:0] MIN_DELAY_C = 16'(MIN_DELAY_MS);
  localparam logic [15:0] RAND_MASK   = 16'((32'd1 << RAND_BITS) - 32'd1);

  logic        start_q;
  logic        react_q;
  logic        live_q;
  logic        start_edge_s;
  logic        react_edge_s;
  logic [15:0] lfsr_s;
  logic [15:0] delay_load_s;

  state_e      state_q;
  logic [15:0] delay_q;
  logic [13:0] count_q;
  logic [13:0] time_q;
  logic        led_q;
  logic        disp_q;

  lfsr16 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clock_i (clock),
    .reset_i (reset),
    .lfsr_o  (lfsr_s)
  );

  // Button history registers; live_q masks edges in the first cycle after
  // reset so that a button held through reset release is not seen as a press
  always_ff @(posedge clock) begin
    if (reset) begin
      start_q <= 1'b0;
      react_q <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      start_q <= start_button;
      react_q <= react_button;
      live_q  <= 1'b1;
    end
  end

  // Single-cycle rising-edge pulses and the random delay for the next trial
  always_comb begin
    start_edge_s = live_q & start_button & ~start_q;
    react_edge_s = live_q & react_button & ~react_q;
    delay_load_s = MIN_DELAY_C + (lfsr_s & RAND_MASK);
  end

  // Game FSM with its counters and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      delay_q <= 16'd0;
      count_q <= 14'd0;
      time_q  <= SENT_IDLE;
      led_q   <= 1'b0;
      disp_q  <= 1'b0;
    end else begin
      disp_q <= 1'b1;
      unique case (state_q)
        ST_IDLE: begin
          led_q <= 1'b0;
          if (start_edge_s) begin
            state_q <= ST_WAIT;
            delay_q <= delay_load_s;
            time_q  <= SENT_LED_BLANK;
          end else begin
            state_q <= ST_IDLE;
            time_q  <= SENT_IDLE;
          end
        end

        ST_WAIT: begin
          if (react_edge_s) begin
            // Early press beats a coincident final strobe
            state_q <= ST_FAIL;
            delay_q <= 16'd0;
            time_q  <= SENT_FAIL;
            led_q   <= 1'b0;
          end else if (rising_edge_1khz) begin
            if (delay_q <= 16'd1) begin
              // This strobe takes the delay to zero: light the stimulus now
              state_q <= ST_ARMED;
              delay_q <= 16'd0;
              count_q <= 14'd0;
              time_q  <= 14'd0;
              led_q   <= 1'b1;
            end else begin
              delay_q <= delay_q - 16'd1;
              time_q  <= SENT_LED_BLANK;
              led_q   <= 1'b0;
            end
          end else begin
            time_q <= SENT_LED_BLANK;
            led_q  <= 1'b0;
          end
        end

        ST_ARMED: begin
          if (react_edge_s) begin
            // Freeze the count; a coincident strobe does not add to it
            state_q <= ST_RESULT;
            time_q  <= count_q;
            led_q   <= 1'b0;
          end else if (rising_edge_1khz) begin
            if (count_q >= MAX_MS) begin
              state_q <= ST_RESULT;
              count_q <= MAX_MS;
              time_q  <= MAX_MS;
              led_q   <= 1'b0;
            end else begin
              count_q <= count_q + 14'd1;
              time_q  <= count_q + 14'd1;
              led_q   <= 1'b1;
            end
          end else begin
            time_q <= count_q;
            led_q  <= 1'b1;
          end
        end

        ST_RESULT, ST_FAIL: begin
          led_q <= 1'b0;
          if (start_edge_s) begin
            state_q <= ST_WAIT;
            delay_q <= delay_load_s;
            time_q  <= SENT_LED_BLANK;
          end else if (state_q == ST_RESULT) begin
            time_q <= count_q;
          end else begin
            time_q <= SENT_FAIL;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          delay_q <= 16'd0;
          count_q <= 14'd0;
          time_q  <= SENT_IDLE;
          led_q   <= 1'b0;
        end
      endcase
    end
  end

  assign time_millisecs = time_q;
  assign stimulus_led   = led_q;
  assign display_enable = disp_q;

endmodule

// File: tb/tb_reaction_timer_core.sv
// -----------------------------------------------------------------------------
// tb_reaction_timer_core
// Directed bench for reaction_timer_core. A reference LFSR tracks the DUT's
// random source so each trial's delay is known in advance.
// -----------------------------------------------------------------------------
module tb_reaction_timer_core;

  localparam logic [31:0] C_FAIL  = 32'h0000_3FFF;
  localparam logic [31:0] C_IDLE  = 32'h0000_3FFE;
  localparam logic [31:0] C_BLANK = 32'h0000_3FFD;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rising_edge_1khz = 1'b0;
  logic        start_button = 1'b0;
  logic        react_button = 1'b0;
  logic [13:0] time_millisecs;
  logic        display_enable;
  logic        stimulus_led;

  logic [15:0] ref_lfsr;
  logic        led_seen;
  int          n_checks = 0;
  int          n_fail = 0;
  int          dly;

  reaction_timer_core dut (
    .clock            (clock),
    .reset            (reset),
    .rising_edge_1khz (rising_edge_1khz),
    .start_button     (start_button),
    .react_button     (react_button),
    .time_millisecs   (time_millisecs),
    .display_enable   (display_enable),
    .stimulus_led     (stimulus_led)
  );

  always #5 clock = ~clock;

  // Reference x^16+x^14+x^13+x^11+1 LFSR, stepped every cycle like the DUT
  always @(posedge clock) begin
    if (reset) ref_lfsr <= 16'hACE1;
    else       ref_lfsr <= {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
  end

  // Sticky record of the LED lighting
  always @(negedge clock) begin
    if (stimulus_led) led_seen = 1'b1;
  end

  task automatic chk_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // n consecutive ms strobes; called and returns at a falling edge
  task automatic strobe(input int n);
    rising_edge_1khz = 1'b1;
    repeat (n) @(negedge clock);
    rising_edge_1khz = 1'b0;
  endtask

  // Start press; returns the delay the DUT loads (sampled at the edge cycle)
  task automatic do_start(output int d);
    d = 1000 + int'(ref_lfsr[10:0]);
    start_button = 1'b1;
    @(negedge clock);
    start_button = 1'b0;
    @(negedge clock);
  endtask

  task automatic press_react;
    react_button = 1'b1;
    @(negedge clock);
    react_button = 1'b0;
    @(negedge clock);
  endtask

  task automatic chk_out(input string tag, input logic [31:0] t, input logic led);
    chk_value({tag, "_time"}, 32'(time_millisecs), t);
    chk_value({tag, "_led"}, 32'(stimulus_led), 32'(led));
  endtask

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge clock);
    chk_out("reset", C_IDLE, 1'b0);
    chk_value("reset_disp", 32'(display_enable), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk_value("disp_after_reset", 32'(display_enable), 32'd1);
    chk_out("idle", C_IDLE, 1'b0);

    // Delay of exactly 1500: start when the random bits read 500
    n = 0;
    while (ref_lfsr[10:0] != 11'd500 && n < 70000) begin
      @(negedge clock);
      n++;
    end
    chk_value("lfsr_search_bound", 32'(n < 70000), 32'd1);
    do_start(dly);
    chk_out("wait_entry", C_BLANK, 1'b0);
    strobe(1499);
    chk_out("wait_1499", C_BLANK, 1'b0);
    strobe(1);
    chk_out("armed_entry", 32'd0, 1'b1);

    // React after 237 strobes
    strobe(237);
    chk_out("armed_live_237", 32'd237, 1'b1);
    press_react();
    chk_out("result_237", 32'd237, 1'b0);
    strobe(5);
    chk_out("result_hold", 32'd237, 1'b0);

    // Early press -> FAIL, LED never lit, then restart
    led_seen = 1'b0;
    do_start(dly);
    chk_out("restart_from_result", C_BLANK, 1'b0);
    strobe(10);
    press_react();
    chk_out("early_fail", C_FAIL, 1'b0);
    strobe(dly);
    chk_out("fail_hold", C_FAIL, 1'b0);
    chk_value("fail_led_never", 32'(led_seen), 32'd0);
    do_start(dly);
    chk_out("restart_from_fail", C_BLANK, 1'b0);

    // Timeout: 10000 strobes without reaction saturate at 9999
    strobe(dly - 1);
    chk_out("t_wait_last", C_BLANK, 1'b0);
    strobe(1);
    chk_out("t_armed", 32'd0, 1'b1);
    strobe(9999);
    chk_out("t_9999", 32'd9999, 1'b1);
    strobe(1);
    chk_out("t_result", 32'd9999, 1'b0);

    // Start ignored in WAIT; react coincident with strobe at count 500
    do_start(dly);
    strobe(10);
    start_button = 1'b1;
    @(negedge clock);
    start_button = 1'b0;
    @(negedge clock);
    strobe(dly - 11);
    chk_out("wait_start_ignored", C_BLANK, 1'b0);
    strobe(1);
    chk_out("armed_after_ignored", 32'd0, 1'b1);
    strobe(500);
    chk_out("armed_500", 32'd500, 1'b1);
    react_button = 1'b1;
    rising_edge_1khz = 1'b1;
    @(negedge clock);
    rising_edge_1khz = 1'b0;
    react_button = 1'b0;
    @(negedge clock);
    chk_out("coincident_500", 32'd500, 1'b0);

    // Reset mid-ARMED with both buttons held through release
    do_start(dly);
    strobe(dly);
    strobe(20);
    chk_out("armed_20", 32'd20, 1'b1);
    react_button = 1'b1;
    start_button = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk_out("mid_reset", C_IDLE, 1'b0);
    chk_value("mid_reset_disp", 32'(display_enable), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    chk_out("held_no_edge", C_IDLE, 1'b0);
    chk_value("held_disp", 32'(display_enable), 32'd1);
    start_button = 1'b0;
    react_button = 1'b0;
    @(negedge clock);
    do_start(dly);
    chk_out("start_after_release", C_BLANK, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
